// File: rtl/mac_pkg.sv
// Shared types and helpers for the multiply-accumulate engine and the filter
// blocks that reuse its multiplier pipeline.
package mac_pkg;

  localparam int DEF_A_W         = 8;
  localparam int DEF_B_W         = 8;
  localparam int DEF_ACC_W       = 20;
  localparam int DEF_MULT_STAGES = 2;
  localparam int PROD_MAX_W      = 32;

  typedef struct packed {
    logic                  valid;
    logic                  up_down;
    logic                  last;
    logic [PROD_MAX_W-1:0] product;
  } payload_t;

  typedef struct packed {
    logic        ovf;
    logic [63:0] val;
  } clip_t;

  typedef enum logic [1:0] {
    S_ACCUM   = 2'd0,
    S_CLOSING = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  function automatic logic signed [63:0] acc_max(input int acc_w);
    return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] acc_min(input int acc_w);
    return -(64'sd1 <<< (acc_w - 1));
  endfunction

  // Without saturation the caller keeps the low acc_w bits of val, which wraps.
  function automatic clip_t sat_clip(input logic signed [63:0] i_sum, input int acc_w,
                                     input logic i_sat);
    clip_t r;
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    mx    = acc_max(acc_w);
    mn    = acc_min(acc_w);
    r.ovf = (i_sum > mx) || (i_sum < mn);
    r.val = i_sum;
    if (i_sat && (i_sum > mx)) r.val = mx;
    else if (i_sat && (i_sum < mn)) r.val = mn;
    return r;
  endfunction

endpackage

// File: rtl/mult_pipe.sv
// Input register followed by STAGES product registers; sideband fields travel
// with the product so downstream logic sees one aligned payload.
module mult_pipe
  import mac_pkg::*;
#(
  parameter int A_W    = DEF_A_W,
  parameter int B_W    = DEF_B_W,
  parameter int STAGES = DEF_MULT_STAGES
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_clr,
  input  logic           i_valid,
  input  logic [A_W-1:0] i_a,
  input  logic [B_W-1:0] i_b,
  input  logic           i_up_down,
  input  logic           i_last,
  output payload_t       o_pl
);

  localparam int P_W = A_W + B_W;

  logic [STAGES:0] r_vld;
  logic [STAGES:0] r_up;
  logic [STAGES:0] r_last;
  logic [A_W-1:0]  r_a_p0;
  logic [B_W-1:0]  r_b_p0;
  logic [P_W-1:0]  r_prod [1:STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (i_clr) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_valid;
      for (int s = 1; s <= STAGES; s++) r_vld[s] <= r_vld[s-1];
    end
  end

  // Stage 0 captures operands; stage 1 multiplies; later stages only delay.
  always_ff @(posedge clk) begin
    r_a_p0    <= i_a;
    r_b_p0    <= i_b;
    r_up[0]   <= i_up_down;
    r_last[0] <= i_last;
    r_prod[1] <= P_W'(r_a_p0) * P_W'(r_b_p0);
    for (int s = 1; s <= STAGES; s++) begin
      r_up[s]   <= r_up[s-1];
      r_last[s] <= r_last[s-1];
    end
    for (int s = 2; s <= STAGES; s++) r_prod[s] <= r_prod[s-1];
  end

  always_comb begin
    o_pl         = '0;
    o_pl.valid   = r_vld[STAGES];
    o_pl.up_down = r_up[STAGES];
    o_pl.last    = r_last[STAGES];
    o_pl.product = PROD_MAX_W'(r_prod[STAGES]);
  end

endmodule

// File: rtl/mac_updown_pipe.sv
// Pipelined multiply-accumulate with per-sample add/subtract, one pending
// frame result at a time, and optional saturation of the accumulator.
module mac_updown_pipe
  import mac_pkg::*;
#(
  parameter int A_W         = DEF_A_W,
  parameter int B_W         = DEF_B_W,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int MULT_STAGES = DEF_MULT_STAGES,
  parameter int SATURATE    = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic             up_down,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);

  localparam int P_W = A_W + B_W;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_accept;
  payload_t                w_pl;
  logic signed [ACC_W:0]   w_acc_ext;
  logic signed [ACC_W:0]   w_prod_ext;
  logic signed [ACC_W:0]   w_sum;
  logic signed [63:0]      w_sum_wide;
  clip_t                   w_clip;
  logic [ACC_W-1:0]        w_acc_next;
  logic [ACC_W-1:0]        r_acc;
  logic                    r_ovf_acc;
  logic [ACC_W-1:0]        r_result;
  logic                    r_ovf;

  assign in_ready  = (r_state == S_ACCUM);
  assign out_valid = (r_state == S_HOLD);
  assign result    = r_result;
  assign ovf       = r_ovf;
  assign w_accept  = in_valid && in_ready;

  mult_pipe #(
    .A_W    (A_W),
    .B_W    (B_W),
    .STAGES (MULT_STAGES)
  ) u_mult (
    .clk       (clk),
    .rst_n     (reset_n),
    .i_clr     (clear),
    .i_valid   (w_accept),
    .i_a       (a),
    .i_b       (b),
    .i_up_down (up_down),
    .i_last    (last),
    .o_pl      (w_pl)
  );

  // Accumulate stage: one guard bit makes the sum exact before clamp/wrap.
  assign w_acc_ext  = {r_acc[ACC_W-1], r_acc};
  assign w_prod_ext = {{(ACC_W + 1 - P_W){1'b0}}, w_pl.product[P_W-1:0]};
  assign w_sum      = w_pl.up_down ? (w_acc_ext + w_prod_ext) : (w_acc_ext - w_prod_ext);
  assign w_sum_wide = 64'(w_sum);
  assign w_clip     = sat_clip(w_sum_wide, ACC_W, SATURATE != 0);
  assign w_acc_next = w_clip.val[ACC_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_ACCUM;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ACCUM:   if (w_accept && last)           w_state_nxt = S_CLOSING;
      S_CLOSING: if (w_pl.valid && w_pl.last)    w_state_nxt = S_HOLD;
      S_HOLD:    if (out_ready)                  w_state_nxt = S_ACCUM;
      default:                                   w_state_nxt = S_ACCUM;
    endcase
    if (clear) w_state_nxt = S_ACCUM;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc     <= '0;
      r_ovf_acc <= 1'b0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
    end else if (clear) begin
      r_acc     <= '0;
      r_ovf_acc <= 1'b0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
    end else if (w_pl.valid) begin
      if (w_pl.last) begin
        r_result  <= w_acc_next;
        r_ovf     <= r_ovf_acc | w_clip.ovf;
        r_acc     <= '0;
        r_ovf_acc <= 1'b0;
      end else begin
        r_acc     <= w_acc_next;
        r_ovf_acc <= r_ovf_acc | w_clip.ovf;
      end
    end
  end

endmodule
